obi_varlat_one_to_n_demux: RTL



---
 rtl/obi_demux_pkg.sv | 44 ++++
 rtl/obi_demux_addr_decoder.sv | 25 ++
 rtl/obi_demux_checker.sv | 30 +++
 rtl/obi_varlat_one_to_n_demux.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/obi_demux_pkg.sv
// Shared types and constants for the OBI 1-to-N variable-latency demux.
// Holds the request/response bundles, the address rule type, the default
// address map and the read data returned by the optional error responder.
package obi_demux_pkg;

    localparam int unsigned DEFAULT_NSLAVE = 4;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

    // end_addr is exclusive
    typedef struct packed {
        logic [31:0] idx;
        logic [31:0] start_addr;
        logic [31:0] end_addr;
    } addr_rule_t;

    // Memory bank, peripheral window, control registers, external window
    localparam addr_rule_t DEFAULT_RULES [DEFAULT_NSLAVE] = '{
        '{idx: 32'd0, start_addr: 32'h0000_0000, end_addr: 32'h0001_0000},
        '{idx: 32'd1, start_addr: 32'h1000_0000, end_addr: 32'h1000_1000},
        '{idx: 32'd2, start_addr: 32'h2000_0000, end_addr: 32'h2000_0100},
        '{idx: 32'd3, start_addr: 32'h3000_0000, end_addr: 32'h3001_0000}
    };

    localparam logic [31:0] ERR_RDATA = 32'hBADA_CCE5;

    // True when addr falls inside the half-open window of the rule
    function automatic logic rule_hit(input addr_rule_t rule, input logic [31:0] addr);
        return (addr >= rule.start_addr) && (addr < rule.end_addr);
    endfunction

endpackage

// File: rtl/obi_demux_addr_decoder.sv
// Combinational address decoder: first matching rule wins.
// Produces the rule's target index and an unmapped flag when nothing matches.
module obi_demux_addr_decoder
    import obi_demux_pkg::*;
#(
    parameter int unsigned NSLAVE = 4,
    parameter int unsigned SEL_W  = 3,
    parameter addr_rule_t  ADDR_RULES [NSLAVE] = DEFAULT_RULES
) (
    input  logic [31:0]      i_addr,
    output logic [SEL_W-1:0] o_sel,
    output logic             o_unmapped
);

    // Walk rules from last to first so the lowest-numbered hit overrides
    always_comb begin
        o_sel      = '0;
        o_unmapped = 1'b1;
        for (int i = NSLAVE - 1; i >= 0; i--) begin
            o_sel      = rule_hit(ADDR_RULES[i], i_addr) ? ADDR_RULES[i].idx[SEL_W-1:0] : o_sel;
            o_unmapped = rule_hit(ADDR_RULES[i], i_addr) ? 1'b0 : o_unmapped;
        end
    end

endmodule

// File: rtl/obi_demux_checker.sv
// Simulation checks for the demux: responses that the demux discards
// (wrong target, or nothing outstanding) and counter overflow.
module obi_demux_checker #(
    parameter int unsigned NTGT            = 4,
    parameter int unsigned SEL_W           = 3,
    parameter int unsigned CNT_W           = 3,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input logic             i_clk,
    input logic             i_rst,
    input logic [CNT_W-1:0] i_cnt,
    input logic [SEL_W-1:0] i_tgt,
    input logic [NTGT-1:0]  i_rvalid
);

    logic w_stray;

    // Flag any rvalid arriving from a port that has nothing outstanding
    always_comb begin
        w_stray = 1'b0;
        for (int t = 0; t < NTGT; t++) begin
            w_stray = w_stray | (i_rvalid[t] & ((i_cnt == '0) | (i_tgt != SEL_W'(t))));
        end
    end

    a_no_stray_rvalid: assert property (@(posedge i_clk) disable iff (i_rst) !w_stray);
    a_cnt_bounded:     assert property (@(posedge i_clk) disable iff (i_rst)
                                        i_cnt <= CNT_W'(MAX_OUTSTANDING));

endmodule

// File: rtl/obi_varlat_one_to_n_demux.sv
// OBI 1-to-N demux with variable-latency, in-order response routing.
// Requests are steered by address; a new target is only accepted once all
// transactions to the previous target have returned, so responses can be
// taken from the single outstanding target without reordering.
// Optional feature macro: OBI_DEMUX_ERR_SLAVE_EN adds an internal error
// responder at target index NSLAVE for unmapped addresses; without it,
// unmapped addresses fall through to slave NSLAVE-1.
module obi_varlat_one_to_n_demux
    import obi_demux_pkg::*;
#(
    parameter int unsigned NSLAVE          = 4,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter addr_rule_t  ADDR_RULES [NSLAVE] = DEFAULT_RULES
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  obi_req_t  master_req_i,
    output obi_resp_t master_resp_o,
    output obi_req_t  slave_req_o  [NSLAVE],
    input  obi_resp_t slave_resp_i [NSLAVE]
);

    localparam int unsigned SEL_W = $clog2(NSLAVE + 1);
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
`ifdef OBI_DEMUX_ERR_SLAVE_EN
    localparam int unsigned NTGT = NSLAVE + 1;
    localparam logic [SEL_W-1:0] UNMAPPED_TGT = SEL_W'(NSLAVE);
`else
    localparam int unsigned NTGT = NSLAVE;
    localparam logic [SEL_W-1:0] UNMAPPED_TGT = SEL_W'(NSLAVE - 1);
`endif

    logic [SEL_W-1:0] w_dec_sel;
    logic             w_dec_unmapped;
    logic [SEL_W-1:0] w_sel;
    logic [NTGT-1:0]  w_tgt_gnt;
    logic [NTGT-1:0]  w_tgt_rvalid;
    logic [31:0]      w_tgt_rdata [NTGT];
    logic             w_sel_gnt;
    logic             w_out_rvalid;
    logic [31:0]      w_out_rdata;
    logic             w_allow;
    logic             w_hs;
    logic             w_resp_live;
    logic             w_rsp_accept;

    logic [CNT_W-1:0] r_cnt;
    logic [SEL_W-1:0] r_tgt;
`ifdef OBI_DEMUX_ERR_SLAVE_EN
    logic             r_err_rvalid;
`endif

    obi_demux_addr_decoder #(
        .NSLAVE     (NSLAVE),
        .SEL_W      (SEL_W),
        .ADDR_RULES (ADDR_RULES)
    ) u_dec (
        .i_addr     (master_req_i.addr),
        .o_sel      (w_dec_sel),
        .o_unmapped (w_dec_unmapped)
    );

    assign w_sel = w_dec_unmapped ? UNMAPPED_TGT : w_dec_sel;

    // Gather grant/response of every target, including the error responder
    always_comb begin
        for (int t = 0; t < NSLAVE; t++) begin
            w_tgt_gnt[t]    = slave_resp_i[t].gnt;
            w_tgt_rvalid[t] = slave_resp_i[t].rvalid;
            w_tgt_rdata[t]  = slave_resp_i[t].rdata;
        end
`ifdef OBI_DEMUX_ERR_SLAVE_EN
        w_tgt_gnt[NSLAVE]    = 1'b1;
        w_tgt_rvalid[NSLAVE] = r_err_rvalid;
        w_tgt_rdata[NSLAVE]  = ERR_RDATA;
`endif
    end

    // Grant comes from the decoded target, response from the outstanding one
    always_comb begin
        w_sel_gnt    = 1'b0;
        w_out_rvalid = 1'b0;
        w_out_rdata  = 32'h0000_0000;
        for (int t = 0; t < NTGT; t++) begin
            w_sel_gnt    = (w_sel == SEL_W'(t)) ? w_tgt_gnt[t]    : w_sel_gnt;
            w_out_rvalid = (r_tgt == SEL_W'(t)) ? w_tgt_rvalid[t] : w_out_rvalid;
            w_out_rdata  = (r_tgt == SEL_W'(t)) ? w_tgt_rdata[t]  : w_out_rdata;
        end
    end

    // Switching target requires a full drain; same target may stack up to MAX
    assign w_allow      = !rst_i && ((r_cnt == '0) || ((w_sel == r_tgt) && (r_cnt < CNT_MAX)));
    assign w_hs         = w_allow && master_req_i.req && w_sel_gnt;
    assign w_resp_live  = !rst_i && (r_cnt != '0);
    assign w_rsp_accept = w_resp_live && w_out_rvalid;

    // Drive slave requests and master response; idle ports are fully zeroed
    always_comb begin
        for (int i = 0; i < NSLAVE; i++) begin
            slave_req_o[i] = (w_allow && (w_sel == SEL_W'(i))) ? master_req_i : '0;
        end
        master_resp_o.gnt    = w_allow && w_sel_gnt;
        master_resp_o.rvalid = w_rsp_accept;
        master_resp_o.rdata  = w_resp_live ? w_out_rdata : 32'h0000_0000;
    end

    // Outstanding counter and target of the outstanding transactions
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= '0;
            r_tgt <= '0;
        end else begin
            case ({w_hs, w_rsp_accept})
                2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
            r_tgt <= w_hs ? w_sel : r_tgt;
        end
    end

`ifdef OBI_DEMUX_ERR_SLAVE_EN
    // Error responder answers every accepted unmapped request one cycle later
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_err_rvalid <= 1'b0;
        end else begin
            r_err_rvalid <= w_hs && (w_sel == UNMAPPED_TGT);
        end
    end
`endif

    obi_demux_checker #(
        .NTGT            (NTGT),
        .SEL_W           (SEL_W),
        .CNT_W           (CNT_W),
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_chk (
        .i_clk    (clk_i),
        .i_rst    (rst_i),
        .i_cnt    (r_cnt),
        .i_tgt    (r_tgt),
        .i_rvalid (w_tgt_rvalid)
    );

endmodule
